// File: rtl/stream_mux_arb_pkg.sv
// Shared types and constants for the stream multiplexer/arbiter block.
// Select policy enum, default data width and the select-index width helper.
package mux_pkg;

    typedef enum logic [0:0] {
        MUX_MODE_SEL = 1'b0,
        MUX_MODE_RR  = 1'b1
    } mux_mode_e;

    localparam int MUX_WIDTH_DEFAULT = 32;

    // Index width is never allowed to collapse to zero bits.
    function automatic int sel_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// Handshake bundle between N_IN upstream channels, the select input and one downstream port.
// The master modport is the environment side, the slave modport is the mux itself.
interface stream_mux_arb_if #(
    parameter int WIDTH = mux_pkg::MUX_WIDTH_DEFAULT,
    parameter int N_IN  = 4
);
    localparam int SW = mux_pkg::sel_width(N_IN);

    logic [WIDTH-1:0] in_data_i [N_IN];
    logic [N_IN-1:0]  in_valid_i;
    logic [N_IN-1:0]  in_ready_o;
    logic [SW-1:0]    sel_i;
    logic [WIDTH-1:0] out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [SW-1:0]    out_src_o;

    modport master (
        output in_data_i, in_valid_i, sel_i, out_ready_i,
        input  in_ready_o, out_data_o, out_valid_o, out_src_o
    );

    modport slave (
        input  in_data_i, in_valid_i, sel_i, out_ready_i,
        output in_ready_o, out_data_o, out_valid_o, out_src_o
    );

endinterface

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Circular first-valid search: grants the first requesting channel at or above ptr,
// wrapping from N_IN-1 back to 0.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int  N_IN = 4,
    localparam int SW   = sel_width(N_IN)
) (
    input  logic [N_IN-1:0] req,
    input  logic [SW-1:0]   ptr,
    output logic            gnt_vld,
    output logic [SW-1:0]   gnt_idx
);

    // ptr is always < N_IN, so a single conditional subtract is enough.
    function automatic logic [SW-1:0] wrap_add(input logic [SW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_IN) sum = sum - N_IN;
        return sum[SW-1:0];
    endfunction

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!gnt_vld && req[wrap_add(ptr, i)]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap_add(ptr, i);
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// N_IN-to-1 valid/ready stream mux with a single registered output stage.
// Grant comes from sel_i (MUX_MODE_SEL) or a round-robin pointer (MUX_MODE_RR).
module stream_mux_arb
    import mux_pkg::*;
#(
    parameter int        WIDTH = MUX_WIDTH_DEFAULT,
    parameter int        N_IN  = 4,
    parameter mux_mode_e MODE  = MUX_MODE_SEL
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    stream_mux_arb_if.slave bus
);

    localparam int            SW   = sel_width(N_IN);
    localparam logic [SW-1:0] LAST = SW'(N_IN - 1);

    logic             load_en;
    logic             xfer;
    logic             gnt_vld;
    logic [SW-1:0]    gnt_idx;
    logic [WIDTH-1:0] data_p1;
    logic [SW-1:0]    src_p1;
    logic             vld_p1;

    assign load_en = !vld_p1 || bus.out_ready_i;
    // rst_ni gates the handshake so no upstream beat is accepted while in reset.
    assign xfer    = gnt_vld && load_en && rst_ni;

    generate
        if (MODE == MUX_MODE_RR) begin : g_rr
            logic [SW-1:0] rr_ptr;

            rr_arbiter #(.N_IN(N_IN)) u_arb (
                .req     (bus.in_valid_i),
                .ptr     (rr_ptr),
                .gnt_vld (gnt_vld),
                .gnt_idx (gnt_idx)
            );

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni)   rr_ptr <= '0;
                else if (xfer) rr_ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
            end
        end else begin : g_sel
            always_comb begin
                gnt_vld = 1'b0;
                gnt_idx = bus.sel_i;
                if (int'(bus.sel_i) < N_IN) gnt_vld = bus.in_valid_i[bus.sel_i];
            end
        end
    endgenerate

    always_comb begin
        bus.in_ready_o = '0;
        if (xfer) bus.in_ready_o[gnt_idx] = 1'b1;
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            src_p1  <= '0;
        end else if (load_en) begin
            vld_p1 <= gnt_vld;
            if (gnt_vld) begin
                data_p1 <= bus.in_data_i[gnt_idx];
                src_p1  <= gnt_idx;
            end
        end
    end

    assign bus.out_data_o  = data_p1;
    assign bus.out_src_o   = src_p1;
    assign bus.out_valid_o = vld_p1;

endmodule

// File: doc/stream_mux_arb.md
STREAM_MUX_ARB -- requirements
Module: stream_mux_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width per channel.
REQ-002 SHALL have parameter N_IN, default 4, meaning input channel count, legal range 2..16.
REQ-003 SHALL have parameter MODE, default MUX_MODE_SEL, meaning select policy: MUX_MODE_SEL (explicit select) or MUX_MODE_RR (round-robin).
REQ-004 SHALL derive SW = max(1, $clog2(N_IN)) as the select/source index width.
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 in_data_i  input  N_IN x WIDTH  channel data, unpacked array indexed by channel.
REQ-008 in_valid_i  input  N_IN  per-channel valid.
REQ-009 in_ready_o  output  N_IN  per-channel ready.
REQ-010 sel_i  input  SW  channel select; used in MUX_MODE_SEL only, ignored in MUX_MODE_RR.
REQ-011 out_data_o  output  WIDTH  registered output data.
REQ-012 out_valid_o  output  1  output register holds a valid beat.
REQ-013 out_ready_i  input  1  downstream ready.
REQ-014 out_src_o  output  SW  index of the channel that produced out_data_o.

Function
REQ-015 A transfer on channel k SHALL occur in a cycle where in_valid_i[k] and in_ready_o[k] are both 1; an output transfer SHALL occur where out_valid_o and out_ready_i are both 1.
REQ-016 load_en SHALL equal (!out_valid_o || out_ready_i); the output stage is a single register with full-throughput pass-through when the downstream is ready.
REQ-017 In MUX_MODE_SEL the grant SHALL be channel sel_i, qualified by in_valid_i[sel_i]; sel_i >= N_IN SHALL grant nothing.
REQ-018 In MUX_MODE_RR the grant SHALL be the first channel with in_valid_i set, searching circularly from rr_ptr upward, wrapping from N_IN-1 to 0.
REQ-019 in_ready_o SHALL be one-hot or zero: in_ready_o[g] = load_en for granted channel g, 0 for all others.
REQ-020 On a channel-g transfer, the next edge SHALL set out_data_o = in_data_i[g], out_src_o = g, and out_valid_o = 1.
REQ-021 When load_en = 1 and no channel is granted, the next edge SHALL clear out_valid_o; out_data_o and out_src_o SHALL hold.
REQ-022 When load_en = 0, out_data_o, out_src_o, and out_valid_o SHALL hold unchanged (stall), independent of in_valid_i or sel_i changes.
REQ-023 Latency SHALL be exactly 1 cycle from input transfer to out_valid_o; sustained throughput SHALL be 1 beat/cycle while out_ready_i = 1.
REQ-024 rr_ptr SHALL update to (g+1) mod N_IN only on a channel-g transfer, and SHALL hold otherwise; in MUX_MODE_SEL, rr_ptr is unused and held at 0.
REQ-025 A simultaneous output transfer and input transfer SHALL replace the register contents with the new beat, with no bubble and no loss.
REQ-026 Behaviour SHALL be fully combinational from in_valid_i, sel_i, and out_ready_i to in_ready_o, with no combinational path from in_data_i to any output.

Reset
REQ-027 While rst_ni = 0, the block SHALL force out_valid_o = 0, out_data_o = 0, out_src_o = 0, and rr_ptr = 0, asynchronously.
REQ-028 in_ready_o SHALL be 0 during reset.
REQ-029 A beat held in the output register when reset asserts SHALL be discarded.
REQ-030 The first grant after reset deassertion in MUX_MODE_RR SHALL search from channel 0.

Structure
REQ-031 Package mux_pkg SHALL hold the mode typedef (MUX_MODE_SEL, MUX_MODE_RR) and the default WIDTH constant, replacing per-file DATA_xx select macros.
REQ-032 Sub-module rr_arbiter (parameter N_IN) SHALL compute the circular first-valid grant from request vector and pointer, and is instantiated only when MODE = MUX_MODE_RR.
REQ-033 Total RTL for the block plus rr_arbiter SHALL be 120-400 lines, with no latches (all combinational outputs fully assigned).

Verification
REQ-034 Reset: hold rst_ni = 0 mid-stream with out_valid_o = 1 -> out_valid_o, out_data_o, and out_src_o all 0 immediately; after release, the first RR grant is channel 0.
REQ-035 SEL mode, N_IN = 4: sel_i = 2, in_valid_i = 4'b1111, in_data_i[2] = 32'hCAFE_0002, out_ready_i = 1 -> in_ready_o = 4'b0100; next cycle out_data_o = 32'hCAFE_0002 and out_src_o = 2.
REQ-036 Stall: out_valid_o = 1 with data 32'h1111, out_ready_i = 0 for 3 cycles while sel_i and the inputs change -> in_ready_o = 0 and the output stays at 32'h1111 on every stall cycle; it updates 1 cycle after out_ready_i = 1.
REQ-037 RR fairness: all 4 channels valid continuously, out_ready_i = 1 -> out_src_o sequence is 0,1,2,3,0,1 with one beat per cycle.
REQ-038 RR wrap and skip: rr_ptr = 3, in_valid_i = 4'b0101 -> grant to channel 0, then channel 2, then channel 0.
REQ-039 Edge cases: SEL mode with sel_i = 3 and in_valid_i[3] = 0 -> no transfer and out_valid_o clears after the current beat drains; with N_IN = 5, sel_i = 7 -> no grant.
